// File: rtl/cla_nibble_serial_adder_pkg.sv
// Shared types for the nibble-serial carry-lookahead adder.
package cla_nibble_serial_adder_pkg;

    // Controller states: IDLE waits for start, RUN walks the nibbles, DONE pulses done.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Nibble width of the shared lookahead slice.
    localparam int unsigned SLICE_W = 4;

endpackage

// File: rtl/cla_nibble_serial_adder_cla4_slice.sv
// Purely combinational 4-bit carry-lookahead adder slice.
module cla4_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    logic [3:0] g;
    logic [3:0] p;
    logic       c1;
    logic       c2;
    logic       c3;

    // Generate/propagate lookahead carries, then sum bits from propagate and carries.
    always_comb begin
        g  = a & b;
        p  = a ^ b;
        c1 = g[0] | (p[0] & ci);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        co = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & ci);
        s  = p ^ {c3, c2, c1, ci};
    end

endmodule

// File: rtl/cla_nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor: one 4-bit lookahead slice reused per nibble, LSB first.
module cla_nibble_serial_adder
    import cla_nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             V
);

    localparam int NIB = WIDTH / 4;
    localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;

    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_width_check
        $error("cla_nibble_serial_adder: WIDTH must be a multiple of 4 and at least 4");
    end

    state_t           state;
    logic [KW-1:0]    k;
    logic             carry;
    logic [WIDTH-1:0] areg;
    logic [WIDTH-1:0] breg;

    logic [SLICE_W-1:0] a_nib;
    logic [SLICE_W-1:0] b_nib;
    logic [SLICE_W-1:0] slice_s;
    logic               slice_co;

    // Select the operand nibbles addressed by k for the shared slice.
    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int unsigned i = 0; i < NIB; i++) begin
            if (k == KW'(i)) begin
                a_nib = areg[4*i +: 4];
                b_nib = breg[4*i +: 4];
            end
        end
    end

    cla4_slice u_slice (
        .a  (a_nib),
        .b  (b_nib),
        .ci (carry),
        .s  (slice_s),
        .co (slice_co)
    );

    // Controller: captures operands, steps one nibble per edge, registers all outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            k     <= '0;
            carry <= 1'b0;
            areg  <= '0;
            breg  <= '0;
            S     <= '0;
            Cout  <= 1'b0;
            V     <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Subtraction is A + ~B + 1; Cin folds into the initial carry.
                        areg  <= A;
                        breg  <= sub ? ~B : B;
                        carry <= Cin ^ sub;
                        k     <= '0;
                        S     <= '0;
                        busy  <= 1'b1;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    for (int unsigned i = 0; i < NIB; i++) begin
                        if (k == KW'(i)) begin
                            S[4*i +: 4] <= slice_s;
                        end
                    end
                    carry <= slice_co;
                    if (k == KW'(NIB - 1)) begin
                        Cout  <= slice_co;
                        // areg^breg^sum at the MSB recovers the carry into the MSB.
                        V     <= slice_co ^ (areg[WIDTH-1] ^ breg[WIDTH-1] ^ slice_s[3]);
                        k     <= '0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cla_nibble_serial_adder.sv
// Self-checking bench for cla_nibble_serial_adder (WIDTH=16): directed table, corner sequences, random vs model.
module tb_cla_nibble_serial_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sub;
    logic [15:0] A;
    logic [15:0] B;
    logic        Cin;
    logic        busy;
    logic        done;
    logic [15:0] S;
    logic        Cout;
    logic        V;

    int checks = 0;
    int errors = 0;

    cla_nibble_serial_adder #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .busy  (busy),
        .done  (done),
        .S     (S),
        .Cout  (Cout),
        .V     (V)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sb;
        logic        ci;
        logic [15:0] s;
        logic        co;
        logic        v;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the effective operands.
    task automatic model(input logic [15:0] a, input logic [15:0] b, input logic sb, input logic ci,
                         output logic [15:0] s, output logic co, output logic v);
        logic [15:0] be;
        logic [16:0] full;
        be   = sb ? ~b : b;
        full = {1'b0, a} + {1'b0, be} + {16'd0, ci ^ sb};
        s    = full[15:0];
        co   = full[16];
        v    = (a[15] == be[15]) && (s[15] != a[15]);
    endtask

    // Issue one operation; observe each cycle after the start edge until IDLE or timeout.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic sb, input logic ci,
                          input bit poke, output int lat, output int busyc, output int dones,
                          output bit timeout);
        A = a; B = b; sub = sb; Cin = ci; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; busyc = 0; dones = 0; timeout = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (busy) busyc++;
            if (done) begin
                dones++;
                if (lat == 0) lat = i + 1;
            end
            if (!busy) begin
                timeout = 1'b0;
                break;
            end
            if (poke && i == 1) begin
                start = 1'b1; A = 16'hFFFF; B = 16'hFFFF; sub = 1'b0; Cin = 1'b0;
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
    endtask

    initial begin
        int          lat;
        int          busyc;
        int          dones;
        bit          to;
        logic [15:0] es;
        logic        ec;
        logic        ev;
        int          seen;

        tbl[0] = '{16'h1234, 16'h0FCD, 1'b0, 1'b0, 16'h2201, 1'b0, 1'b0};
        tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[3] = '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0};
        tbl[4] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        tbl[5] = '{16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0};

        rst = 1'b1; start = 1'b0; sub = 1'b0; A = '0; B = '0; Cin = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_S", 32'(S), 32'h0);
        chk("reset_Cout", 32'(Cout), 32'h0);
        chk("reset_V", 32'(V), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_done", 32'(done), 32'h0);

        // Directed table with latency and handshake checks.
        for (int i = 0; i < 6; i++) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].sb, tbl[i].ci, 1'b0, lat, busyc, dones, to);
            chk($sformatf("tbl%0d_timeout", i), 32'(to), 32'h0);
            chk($sformatf("tbl%0d_S", i), 32'(S), 32'(tbl[i].s));
            chk($sformatf("tbl%0d_Cout", i), 32'(Cout), 32'(tbl[i].co));
            chk($sformatf("tbl%0d_V", i), 32'(V), 32'(tbl[i].v));
            chk($sformatf("tbl%0d_dones", i), 32'(dones), 32'd1);
            chk($sformatf("tbl%0d_latency_edges", i), 32'(lat), 32'd5);
            chk($sformatf("tbl%0d_busy_cycles", i), 32'(busyc), 32'd5);
        end

        // Start while busy is ignored; result holds through IDLE.
        run_op(16'h1234, 16'h0FCD, 1'b0, 1'b0, 1'b1, lat, busyc, dones, to);
        chk("poke_timeout", 32'(to), 32'h0);
        chk("poke_S", 32'(S), 32'h2201);
        chk("poke_dones", 32'(dones), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("hold_S", 32'(S), 32'h2201);
        chk("hold_busy", 32'(busy), 32'h0);

        // Reset on RUN edge 2 abandons the operation.
        A = 16'h1234; B = 16'h0FCD; sub = 1'b0; Cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_S", 32'(S), 32'h0);
        chk("midrst_Cout", 32'(Cout), 32'h0);
        chk("midrst_V", 32'(V), 32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_done", 32'(done), 32'h0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        chk("midrst_no_done", 32'(seen), 32'd0);
        run_op(16'h0003, 16'h0004, 1'b0, 1'b0, 1'b0, lat, busyc, dones, to);
        chk("after_rst_timeout", 32'(to), 32'h0);
        chk("after_rst_S", 32'(S), 32'h0007);

        // Randomized operations against the arithmetic model.
        for (int i = 0; i < 40; i++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            logic        rs;
            logic        rc;
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom_range(0, 1));
            rc = 1'($urandom_range(0, 1));
            model(ra, rb, rs, rc, es, ec, ev);
            run_op(ra, rb, rs, rc, 1'b0, lat, busyc, dones, to);
            chk($sformatf("rnd%0d_S a=%h b=%h sub=%b cin=%b", i, ra, rb, rs, rc), 32'(S), 32'(es));
            chk($sformatf("rnd%0d_CoutV", i), {30'd0, Cout, V}, {30'd0, ec, ev});
            chk($sformatf("rnd%0d_lat_dones", i), 32'((lat << 4) | dones), 32'((5 << 4) | 1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
